mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, meaning memory access latency in cycles (legal 1..15).
REQ-002 SHALL have parameter AW, default 16, meaning address width.
REQ-003 SHALL have parameter DW, default 16, meaning data width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port if_req  input  1  meaning instruction-fetch read request, held until if_ready.
REQ-007 SHALL have port if_addr  input  AW  meaning fetch address.
REQ-008 SHALL have port if_rdata  output  DW  meaning fetched instruction.
REQ-009 SHALL have port if_ready  output  1  meaning one-cycle completion pulse for fetch.
REQ-010 SHALL have port dm_req  input  1  meaning data-memory request, held until dm_ready.
REQ-011 SHALL have port dm_wr  input  1  meaning 1 = write, 0 = read.
REQ-012 SHALL have port dm_addr  input  AW  meaning data address.
REQ-013 SHALL have port dm_wdata  input  DW  meaning write data.
REQ-014 SHALL have port dm_rdata  output  DW  meaning read data.
REQ-015 SHALL have port dm_ready  output  1  meaning one-cycle completion pulse for data access (reads and writes).
REQ-016 SHALL have port mem_en, mem_wr  output  1 each  meaning enable and write strobe to the shared single-port memory.
REQ-017 SHALL have port mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW  meaning the shared memory bus.
REQ-018 SHALL have port busy  output  1  meaning high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-020 In IDLE, SHALL grant on the clock edge at which any req is high; with both high, dm wins (fixed priority).
REQ-021 At grant, SHALL register the requester ID, address, dm_wr and dm_wdata; later input changes SHALL be ignored until the next grant.
REQ-022 In BUSY, SHALL drive mem_en=1, mem_addr/mem_wdata from the registers, and mem_wr=1 only for a granted dm write.
REQ-023 SHALL load a down-counter with MEM_LAT-1 at grant and stay in BUSY for exactly MEM_LAT cycles.
REQ-024 When the counter reaches 0, SHALL capture mem_rdata into the granted port's rdata register for reads and go to RESP.
REQ-025 In RESP, SHALL assert exactly one of if_ready/dm_ready for one cycle, drive mem_en=0, sample no requests, then return to IDLE.
REQ-026 Timing: a req high in an IDLE cycle t SHALL see ready in cycle t+MEM_LAT+1; throughput is one access per MEM_LAT+2 cycles.
REQ-027 if_rdata/dm_rdata SHALL hold their last captured value until the next read completes on that port; a dm write SHALL leave dm_rdata unchanged.
REQ-028 A req dropped during BUSY SHALL NOT abort the access; ready SHALL still pulse.
REQ-029 A req held through RESP into IDLE SHALL be treated as a new request.

Reset
REQ-030 On rst_n low, SHALL immediately enter IDLE and clear counter, registered request, rdata registers, last-grant flag and every output to 0; an in-flight memory access SHALL be dropped (mem_en falls asynchronously).
REQ-031 After rst_n rises, the first edge SHALL behave as IDLE.

Configuration
REQ-032 With macro MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin by a last-grant flag; after reset, dm wins the first tie.
REQ-033 Without MEM_ARB_RR_EN, SHALL use fixed dm priority, with no last-grant flag.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state typedef (IDLE=2'b00, BUSY=2'b01, RESP=2'b10), the requester-ID typedef (PORT_IF, PORT_DM) and the default latency constant.
REQ-035 The latency down-counter SHALL be a separate sub-module mem_arb_lat_cnt (load, decrement, zero flag).

Verification (MEM_LAT=4)
REQ-036 if_req=1, if_addr=16'h0010, mem returns 16'hA5A5 -> mem_en high cycles 1-4, if_ready pulse in cycle 5, if_rdata=16'hA5A5.
REQ-037 if_req and dm_req both high in the same cycle -> dm served first (dm_ready cycle 5), then if_ready in cycle 11; with MEM_ARB_RR_EN a second tie grants if first.
REQ-038 dm write addr 16'h0020, data 16'h1234 -> mem_wr=1 for 4 cycles, dm_ready pulses, dm_rdata unchanged; a following read returns 16'h1234.
REQ-039 dm_req held continuously, fixed priority -> if_ready never asserts (starvation observed); with MEM_ARB_RR_EN, grants alternate.
REQ-040 rst_n low in cycle 2 of BUSY -> mem_en/busy fall the same cycle, no ready pulse; a new request after release completes normally.
REQ-041 dm_req dropped in cycle 2 of BUSY -> dm_ready still pulses in cycle 5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_id_e;

    localparam int unsigned MEM_LAT_DEFAULT = 4;
    localparam int unsigned LAT_CNT_W       = 4;

    // prefer_if breaks a tie towards fetch; tied low, data always wins.
    function automatic port_id_e pick_port(
        input logic if_req,
        input logic dm_req,
        input logic prefer_if
    );
        if (dm_req && !(if_req && prefer_if)) begin
            return PORT_DM;
        end
        return PORT_IF;
    endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency down-counter: loadable, decrementing, with a zero flag.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// access. Define MEM_ARB_RR_EN for round-robin ties; default is fixed dm priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e state;
    port_id_e   grant_port;
    port_id_e   win_port;
    logic       any_req;
    logic       lat_load;
    logic       lat_dec;
    logic       lat_zero;

`ifdef MEM_ARB_RR_EN
    logic       last_dm;
`endif

    always_comb begin
        any_req = if_req | dm_req;
`ifdef MEM_ARB_RR_EN
        win_port = pick_port(if_req, dm_req, last_dm);
`else
        win_port = pick_port(if_req, dm_req, 1'b0);
`endif
        lat_load = (state == IDLE) && any_req;
        lat_dec  = (state == BUSY) && !lat_zero;
    end

    mem_arb_lat_cnt #(
        .W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (LAT_CNT_W'(MEM_LAT - 1)),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    // mem_addr/mem_wdata double as the granted-request registers; mem_wr is
    // only ever set for a dm write and is cleared when BUSY ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_port <= PORT_IF;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            busy       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm    <= 1'b0;
`endif
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_port <= win_port;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= BUSY;
                        if (win_port == PORT_DM) begin
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_wr    <= dm_wr;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wr    <= 1'b0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_dm <= (win_port == PORT_DM);
`endif
                    end
                end
                BUSY: begin
                    if (lat_zero) begin
                        if (!mem_wr) begin
                            if (grant_port == PORT_DM) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if_ready <= (grant_port == PORT_IF);
                        dm_ready <= (grant_port == PORT_DM);
                        mem_en   <= 1'b0;
                        mem_wr   <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a transaction-level schedule model.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;

    localparam int L  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_wr = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(
        .MEM_LAT (L),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter, indexed by the low address byte.
    logic [DW-1:0] env_mem [256];
    assign mem_rdata = mem_en ? env_mem[mem_addr[7:0]] : '0;
    always @(posedge clk) begin
        if (mem_en && mem_wr) env_mem[mem_addr[7:0]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: one access occupies cycles g+1..g+L (memory enabled)
    // and g+L+1 (response); the arbiter is free again from g+L+2.
    bit            act = 0;
    int            g = 0;
    int            gp = 0;
    logic [15:0]   g_addr = '0;
    logic [15:0]   g_wdata = '0;
    bit            g_wr = 0;
    int            idle_from = 0;
    bit            last_dm = 0;
    logic [15:0]   ref_mem [256];
    logic [15:0]   exp_ifr = '0;
    logic [15:0]   exp_dmr = '0;
    int            served [2] = '{0, 0};
    int            dut_rdy [2] = '{0, 0};

    // Requester agents: 0 = fetch, 1 = data. mode 0 random, 1 always busy, 2 quiet.
    bit            pend [2] = '{0, 0};
    bit            in_svc [2] = '{0, 0};
    bit            req_v [2] = '{0, 0};
    logic [15:0]   a_addr [2];
    logic [15:0]   a_wdata [2];
    bit            a_wr [2] = '{0, 0};
    int            mode = 2;

    task automatic check_outputs();
        bit e_busy;
        bit e_en;
        bit e_resp;
        bit e_rdy [2];
        e_rdy  = '{0, 0};
        e_busy = act && (cyc >= g + 1) && (cyc <= g + L + 1);
        e_en   = act && (cyc >= g + 1) && (cyc <= g + L);
        e_resp = act && (cyc == g + L + 1);
        if (e_resp) begin
            e_rdy[gp] = 1;
            if (g_wr) ref_mem[g_addr[7:0]] = g_wdata;
            else if (gp == 1) exp_dmr = ref_mem[g_addr[7:0]];
            else exp_ifr = ref_mem[g_addr[7:0]];
        end
        if (if_ready === 1'b1) dut_rdy[0]++;
        if (dm_ready === 1'b1) dut_rdy[1]++;
        chk("busy", 16'(busy), 16'(e_busy));
        chk("mem_en", 16'(mem_en), 16'(e_en));
        chk("mem_wr", 16'(mem_wr), 16'(e_en && g_wr));
        if (e_en) chk("mem_addr", mem_addr, g_addr);
        if (e_en && g_wr) chk("mem_wdata", mem_wdata, g_wdata);
        chk("if_ready", 16'(if_ready), 16'(e_rdy[0]));
        chk("dm_ready", 16'(dm_ready), 16'(e_rdy[1]));
        chk("if_rdata", if_rdata, exp_ifr);
        chk("dm_rdata", dm_rdata, exp_dmr);
        if (e_resp) begin
            act        = 0;
            pend[gp]   = 0;
            in_svc[gp] = 0;
            served[gp]++;
        end
    endtask

    task automatic drive_and_grant();
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0))) begin
                pend[p]    = 1;
                a_addr[p]  = {8'($urandom), 8'($urandom_range(0, 31))};
                a_wr[p]    = (p == 1) ? 1'($urandom) : 1'b0;
                a_wdata[p] = 16'($urandom);
            end
            req_v[p] = pend[p] && (!in_svc[p] || mode == 1 || $urandom_range(0, 1) == 1);
        end
        // Once granted, the driven address/data are scrambled: the design must not care.
        if_req   = req_v[0];
        if_addr  = in_svc[0] ? 16'($urandom) : a_addr[0];
        dm_req   = req_v[1];
        dm_wr    = in_svc[1] ? 1'($urandom) : a_wr[1];
        dm_addr  = in_svc[1] ? 16'($urandom) : a_addr[1];
        dm_wdata = in_svc[1] ? 16'($urandom) : a_wdata[1];
        if (!act && cyc >= idle_from && (req_v[0] || req_v[1])) begin
            if (req_v[0] && req_v[1]) begin
`ifdef MEM_ARB_RR_EN
                gp = last_dm ? 0 : 1;
`else
                gp = 1;
`endif
            end else begin
                gp = req_v[1] ? 1 : 0;
            end
            act        = 1;
            g          = cyc;
            g_addr     = a_addr[gp];
            g_wr       = a_wr[gp];
            g_wdata    = a_wdata[gp];
            in_svc[gp] = 1;
            last_dm    = (gp == 1);
            idle_from  = cyc + L + 2;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_and_grant();
    endtask

    task automatic wait_quiet();
        for (int n = 0; n < 100 && (act || pend[0] || pend[1]); n++) cycle();
    endtask

    task automatic inject(input int p, input bit wr, input logic [15:0] addr, input logic [15:0] data);
        pend[p]    = 1;
        in_svc[p]  = 0;
        a_wr[p]    = wr;
        a_addr[p]  = addr;
        a_wdata[p] = data;
    endtask

    task automatic serve(input int p, input bit wr, input logic [15:0] addr, input logic [15:0] data);
        wait_quiet();
        inject(p, wr, addr, data);
        wait_quiet();
    endtask

    task automatic reset_model();
        act     = 0;
        exp_ifr = '0;
        exp_dmr = '0;
        last_dm = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p]   = 0;
            in_svc[p] = 0;
            req_v[p]  = 0;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic mid_busy_reset();
        wait_quiet();
        inject(1, 1'b0, 16'h0003, 16'h0000);
        for (int n = 0; n < 20 && !(act && cyc == g + 1); n++) cycle();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_mem_en", 16'(mem_en), 16'h0000);
        chk("rst_mem_wr", 16'(mem_wr), 16'h0000);
        chk("rst_if_ready", 16'(if_ready), 16'h0000);
        chk("rst_dm_ready", 16'(dm_ready), 16'h0000);
        chk("rst_if_rdata", if_rdata, 16'h0000);
        chk("rst_dm_rdata", dm_rdata, 16'h0000);
        reset_model();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle_from = cyc;
        inject(0, 1'b0, 16'h0011, 16'h0000);
        drive_and_grant();
        wait_quiet();
    endtask

    initial begin
        int if0;
        int dm0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 16'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[8'h10] = 16'hA5A5;
        ref_mem[8'h10] = 16'hA5A5;

        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        idle_from = cyc;
        drive_and_grant();

        serve(0, 1'b0, 16'h0010, 16'h0000);
        chk("if_rdata_a5a5", if_rdata, 16'hA5A5);
        serve(1, 1'b1, 16'h0020, 16'h1234);
        serve(1, 1'b0, 16'h0020, 16'h0000);
        chk("dm_rdata_1234", dm_rdata, 16'h1234);

        // Two back-to-back simultaneous requests.
        for (int t = 0; t < 2; t++) begin
            wait_quiet();
            inject(0, 1'b0, 16'h0005, 16'h0000);
            inject(1, 1'b0, 16'h0006, 16'h0000);
            wait_quiet();
        end

        // Both requesters held continuously.
        if0 = dut_rdy[0];
        dm0 = dut_rdy[1];
        mode = 1;
        repeat (60) cycle();
        mode = 2;
        wait_quiet();
        chk("held_if_grants", 16'(dut_rdy[0] - if0), 16'(served[0] - if0));
        chk("held_dm_grants", 16'(dut_rdy[1] - dm0), 16'(served[1] - dm0));

        mid_busy_reset();

        mode = 0;
        repeat (1500) cycle();
        mode = 2;
        wait_quiet();
        repeat (4) cycle();
        chk("if_ready_count", 16'(dut_rdy[0]), 16'(served[0]));
        chk("dm_ready_count", 16'(dut_rdy[1]), 16'(served[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
